// File: rtl/dm_sb_pkg.sv
// dm_sb_pkg: FSM encoding and default queue depth shared by the store buffer modules.
package dm_sb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, READ = 2'd2} sb_state_t;
    localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/dm_sb_queue.sv
// dm_sb_queue: circular store queue with youngest-match forwarding lookup.
module dm_sb_queue
    import dm_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      skip,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      hit,
    output logic [DATA_WIDTH-1:0]     hit_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign full     = count == CW'(DEPTH);
    // skip selects the entry behind the head so a back-to-back drain can start on the pop edge
    assign out_addr = addr_q[head + PW'(skip)];
    assign out_data = data_q[head + PW'(skip)];
    // walk oldest to youngest so the last match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && addr_q[head + PW'(i)] == lookup_addr) begin
                hit      = 1'b1;
                hit_data = data_q[head + PW'(i)];
            end
        end
    end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store buffer between the MEM stage and a ready-handshake data memory.
module dm_store_buffer
    import dm_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic [DATA_WIDTH-1:0] dm_r_data,
    output logic                  dm_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_ready,
    output logic                  sb_empty
);
    localparam int CW = $clog2(DEPTH) + 1;
    sb_state_t             state;
    sb_state_t             next_state;
    logic                  push;
    logic                  pop;
    logic                  hit;
    logic                  miss;
    logic                  full;
    logic                  start_rd;
    logic                  start_wr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] hit_data;
    dm_sb_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .push_addr   (dm_addr),
        .push_data   (dm_w_data),
        .skip        (pop),
        .lookup_addr (dm_addr),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .hit         (hit),
        .hit_data    (hit_data),
        .count       (count),
        .full        (full)
    );
    assign miss     = dm_rd && !dm_wr && !hit;
    assign pop      = state == DRAIN && mem_ready;
    // a full queue still takes the store on the edge that frees the head slot
    assign push     = dm_wr && (!full || pop);
    assign dm_stall = (dm_wr && !push) || (miss && !(state == READ && mem_ready));
    assign sb_empty = count == '0 && state == IDLE;
    always_comb begin
        start_rd   = miss && (state == IDLE || pop);
        start_wr   = !miss && (state == IDLE ? count != '0 : pop && count > CW'(1));
        next_state = start_rd ? READ : start_wr ? DRAIN : mem_ready ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
            dm_r_data  <= '0;
        end else begin
            state  <= next_state;
            mem_rd <= next_state == READ;
            mem_wr <= next_state == DRAIN;
            if (start_wr) begin
                mem_addr   <= out_addr;
                mem_w_data <= out_data;
            end else if (start_rd) begin
                mem_addr <= dm_addr;
            end
            if (state == READ && mem_ready)
                dm_r_data <= mem_r_data;
            else if (dm_rd && !dm_wr && hit)
                dm_r_data <= hit_data;
        end
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed scoreboard bench for dm_store_buffer with a variable-latency memory model.
module tb_dm_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dm_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_w_data;
    logic [15:0] dm_r_data;
    logic        dm_stall;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_w_data;
    logic [15:0] mem_r_data;
    logic        mem_ready;
    logic        sb_empty;

    int          ncmp = 0;
    int          nerr = 0;
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    bit          mem_en = 1'b0;
    bit          pulse  = 1'b0;
    int          lat    = 1;
    int          cnt    = 0;

    dm_store_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .dm_addr    (dm_addr),
        .dm_rd      (dm_rd),
        .dm_wr      (dm_wr),
        .dm_w_data  (dm_w_data),
        .dm_r_data  (dm_r_data),
        .dm_stall   (dm_stall),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .mem_ready  (mem_ready),
        .sb_empty   (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory model: completes each request lat cycles after it appears, or on a one-shot pulse
    initial begin
        logic [23:0] e;
        mem_ready  = 1'b0;
        mem_r_data = '0;
        forever begin
            @(negedge clk);
            if (!rst || mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_rd || mem_wr) begin
                chk("rd_wr_exclusive", mem_rd & mem_wr, 0);
                cnt++;
                if (pulse || (mem_en && cnt >= lat)) begin
                    pulse     = 1'b0;
                    mem_ready = 1'b1;
                    if (mem_wr) begin
                        chk("write_expected", exp_wr.size() > 0, 1);
                        if (exp_wr.size() > 0) begin
                            e = exp_wr.pop_front();
                            chk("write_addr", mem_addr, e[23:16]);
                            chk("write_data", mem_w_data, e[15:0]);
                        end
                        mem[mem_addr] = mem_w_data;
                    end else begin
                        mem_r_data = mem[mem_addr];
                    end
                end
            end
        end
    end

    task automatic store(input logic [7:0] a, input logic [15:0] d);
        int n = 0;
        dm_wr = 1'b1; dm_rd = 1'b0; dm_addr = a; dm_w_data = d;
        while (n < 300) begin
            #1;
            if (!dm_stall) break;
            n++;
            @(negedge clk);
        end
        chk("store_accept_bound", n < 300, 1);
        @(posedge clk);
        exp_wr.push_back({a, d});
        ref_mem[a] = d;
        @(negedge clk);
        dm_wr = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, output int stalls);
        logic [15:0] e;
        stalls = 0;
        dm_rd = 1'b1; dm_wr = 1'b0; dm_addr = a;
        exp_rd.push_back(ref_mem[a]);
        while (stalls < 300) begin
            #1;
            if (!dm_stall) break;
            stalls++;
            @(negedge clk);
        end
        chk("load_stall_bound", stalls < 300, 1);
        @(negedge clk);
        dm_rd = 1'b0;
        e = exp_rd.pop_front();
        chk("load_data", dm_r_data, e);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            if (sb_empty) break;
            @(negedge clk);
        end
        chk("drain_done", sb_empty, 1);
    endtask

    initial begin
        int         st;
        logic [7:0] a;
        rst = 1'b0; dm_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_w_data = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h1000 + 16'(i);
            ref_mem[i] = mem[i];
        end
        mem[8'h40]     = 16'hCAFE;
        ref_mem[8'h40] = 16'hCAFE;
        repeat (2) @(negedge clk);
        chk("rst_dm_r_data", dm_r_data, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dm_stall", dm_stall, 0);
        chk("rst_sb_empty", sb_empty, 1);
        rst = 1'b1;
        @(negedge clk);

        // forwarding from a queued store while memory never answers
        store(8'h12, 16'hBEEF);
        load(8'h12, st);
        chk("fwd_no_stall", st, 0);
        chk("fwd_drain_started", {mem_wr, mem_addr}, {1'b1, 8'h12});

        // youngest duplicate wins, both reach memory in order
        store(8'h05, 16'h1111);
        store(8'h05, 16'h2222);
        load(8'h05, st);
        chk("youngest_no_stall", st, 0);
        mem_en = 1'b1; lat = 1;
        wait_empty();

        // full queue: fifth store stalls until the pop edge, then count is back at DEPTH
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) store(8'h20 + 8'(i), 16'h2000 + 16'(i));
        dm_wr = 1'b1; dm_addr = 8'h24; dm_w_data = 16'h2004;
        #1 chk("full_stall", dm_stall, 1);
        @(negedge clk);
        #1 chk("full_stall_hold", dm_stall, 1);
        pulse = 1'b1;
        @(negedge clk);
        #1 chk("accept_on_pop", dm_stall, 0);
        @(posedge clk);
        exp_wr.push_back({8'h24, 16'h2004});
        ref_mem[8'h24] = 16'h2004;
        @(negedge clk);
        dm_addr = 8'h25; dm_w_data = 16'h2005;
        #1 chk("still_full", dm_stall, 1);
        mem_en = 1'b1; lat = 1;
        store(8'h25, 16'h2005);
        wait_empty();

        // load miss behind an in-flight write, three-cycle memory
        lat = 3;
        store(8'h30, 16'h0A0A);
        @(negedge clk);
        chk("drain_in_flight", mem_wr, 1);
        load(8'h40, st);
        chk("miss_stall_cycles", st, 6);
        chk("write_before_read", exp_wr.size(), 0);

        // asynchronous reset in the middle of a drain abandons everything
        mem_en = 1'b0; lat = 1;
        store(8'h50, 16'h5050);
        store(8'h51, 16'h5151);
        store(8'h52, 16'h5252);
        @(negedge clk);
        chk("pre_rst_drain", mem_wr, 1);
        rst = 1'b0;
        #1;
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_mem_rd", mem_rd, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_w_data", mem_w_data, 0);
        chk("arst_dm_r_data", dm_r_data, 0);
        chk("arst_dm_stall", dm_stall, 0);
        chk("arst_sb_empty", sb_empty, 1);
        exp_wr.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        repeat (2) @(negedge clk);
        rst = 1'b1; mem_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_write_after_rst", mem_wr, 0);
        end

        // pointer wrap across addresses FE..01
        for (int i = 0; i < 12; i++) begin
            a = 8'hFE + 8'(i % 4);
            store(a, 16'h6000 + 16'(i));
            if (i % 3 == 2) load(a - 8'd1, st);
        end
        wait_empty();
        for (int k = 0; k < 4; k++) begin
            a = 8'hFE + 8'(k);
            chk("wrap_mem", mem[a], ref_mem[a]);
            load(a, st);
        end
        chk("scoreboard_drained", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
